// File: rtl/scanline_fetcher.sv
// Double-buffered scanline fetcher: bursts one 640-word RGB565 line from memory while the other line is displayed.
// Optional feature: define SCANLINE_FETCHER_STATS_EN to enable the saturating underrun line counter.
module scanline_fetcher #(
   parameter logic [23:0] FB_BASE        = 24'h000000,
   parameter int          BURST_LEN      = 16,
   parameter logic [15:0] UNDERRUN_COLOR = 16'hF81F
) (
   input  logic        clk_pixel,
   input  logic        rst,
   input  logic        display_enable,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        vsync,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [23:0] mem_req_addr,
   input  logic        mem_rd_valid,
   input  logic [15:0] mem_rd_data,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic        underrun,
   output logic [15:0] underrun_count
);
   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
   localparam logic [6:0] LAST_BEAT = 7'(BURST_LEN - 1);

   state_t      state, state_next;
   logic        vsync_d, de_d;
   logic [9:0]  active_y, fetch_line, pending_line, trig_line, start_line, column;
   logic [6:0]  beat_cnt;
   logic        pending, trig, start, beat, burst_done, line_done;
   logic        vsync_fall, de_fall, de_rise, under_now, line_under;
   logic [1:0]  bank_valid, bank_valid_next;
   logic [23:0] line_base, req_addr;
   logic [15:0] line_buf [0:1][0:639];

   // pixel_y reads 0 in blanking, so the line number is latched while active
   always_comb begin
      vsync_fall = vsync_d & ~vsync;
      de_fall    = de_d & ~display_enable;
      de_rise    = ~de_d & display_enable;
      trig       = vsync_fall | (de_fall & (active_y < 10'd479));
      trig_line  = vsync_fall ? 10'd0 : active_y + 10'd1;
      start      = (state == IDLE) & (trig | pending);
      start_line = trig ? trig_line : pending_line;
      beat       = (state == DATA) & mem_rd_valid;
      burst_done = beat & (beat_cnt == LAST_BEAT);
      line_done  = burst_done & (column == 10'd639);
      under_now  = de_rise ? ~bank_valid[pixel_y[0]] : line_under;
      line_base  = ({14'd0, fetch_line} << 9) + ({14'd0, fetch_line} << 7);
      req_addr   = FB_BASE + line_base + {14'd0, column};
   end

   always_comb begin
      bank_valid_next = bank_valid;
      if (line_done) bank_valid_next[fetch_line[0]] = 1'b1;
      if (start)     bank_valid_next[start_line[0]] = 1'b0;
      if (de_fall)   bank_valid_next[active_y[0]]   = 1'b0;
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = REQ;
         REQ:     if (mem_req_ready) state_next = DATA;
         DATA:    if (burst_done) state_next = line_done ? IDLE : REQ;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid = (state == REQ);
      mem_req_addr  = (state == REQ) ? req_addr : 24'd0;
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         vsync_d      <= 1'b1;
         de_d         <= 1'b0;
         active_y     <= 10'd0;
         pending      <= 1'b0;
         pending_line <= 10'd0;
         fetch_line   <= 10'd0;
         column       <= 10'd0;
         beat_cnt     <= 7'd0;
         bank_valid   <= 2'b00;
      end else begin
         vsync_d    <= vsync;
         de_d       <= display_enable;
         bank_valid <= bank_valid_next;
         if (display_enable) active_y <= pixel_y;
         // a newer trigger always replaces whatever was waiting
         if (start) begin
            pending    <= 1'b0;
            fetch_line <= start_line;
            column     <= 10'd0;
            beat_cnt   <= 7'd0;
         end else if (trig) begin
            pending      <= 1'b1;
            pending_line <= trig_line;
         end
         if (beat) begin
            beat_cnt <= burst_done ? 7'd0 : beat_cnt + 7'd1;
            column   <= line_done ? 10'd0 : column + 10'd1;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (beat) line_buf[fetch_line[0]][column] <= mem_rd_data;
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         pixel_data  <= 16'd0;
         pixel_valid <= 1'b0;
         underrun    <= 1'b0;
         line_under  <= 1'b0;
      end else begin
         pixel_valid <= display_enable;
         if (de_rise) line_under <= ~bank_valid[pixel_y[0]];
         if (de_rise && !bank_valid[pixel_y[0]]) underrun <= 1'b1;
         if (!display_enable) pixel_data <= 16'd0;
         else if (under_now)  pixel_data <= UNDERRUN_COLOR;
         else                 pixel_data <= line_buf[pixel_y[0]][pixel_x];
      end
   end

`ifdef SCANLINE_FETCHER_STATS_EN
   logic [15:0] count_q;

   always_ff @(posedge clk_pixel) begin
      if (rst) count_q <= 16'd0;
      else if (de_rise && !bank_valid[pixel_y[0]] && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
   end

   assign underrun_count = count_q;
`else
   assign underrun_count = 16'd0;
`endif

endmodule
